i2s_frame_sequencer: RTL and testbench

- Sequences serial capture of the AD1868-side stereo sample stream.
- Tracks the LR/latch frame clock and generates the bit-capture window.
- Shifts the left and right serial data into 16-bit words, checks frame length and hands each completed sample pair to the downstream consumer over a valid/ready interface.
- Sits between the pad-side serial inputs and the I2S output formatter; replaces free-running counter control with lock tracking and overrun handling.

---
 rtl/i2s_frame_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_i2s_frame_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_sequencer.sv
// ---------------------------------------------------------------------------
// i2s_frame_sequencer
//
// Captures the AD1868-side stereo serial stream. The block follows the
// LR/latch frame clock, opens a bit-capture window at a fixed offset into
// each frame, shifts left/right data MSB first into WIDTH-bit words, checks
// that every frame is exactly FRAME_LEN bit clocks long, and hands each
// completed sample pair to the downstream consumer over valid/ready.
//
// Frame tracking states:
//   HUNT   - no frame timing known; data ignored until a latch falling edge.
//   SYNC   - one edge seen, frame length not yet confirmed.
//   LOCKED - last frame ended exactly on FRAME_LEN.
//
// Ports:
//   i_clk        bit clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_latch      LR/latch frame clock; falling edge marks frame start
//   i_data_l     left serial data, MSB first
//   i_data_r     right serial data, MSB first
//   o_data_l     held left sample
//   o_data_r     held right sample
//   o_valid      held sample pair is valid
//   i_ready      consumer accepts when o_valid & i_ready
//   o_locked     frame timing locked
//   o_frame_err  one-cycle pulse on an early or lost latch edge
//   o_overrun    one-cycle pulse when a completed pair is dropped
//   o_capture_en high in cycles where a data bit is shifted in
//
// Build option:
//   I2S_SEQ_MUTE_ON_ERROR_EN - when defined, the two commits following any
//   frame error load zero words instead of the captured data.
// ---------------------------------------------------------------------------
module i2s_frame_sequencer #(
    parameter int unsigned FRAME_LEN = 32,
    parameter int unsigned SKIP      = 13,
    parameter int unsigned WIDTH     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_latch,
    input  logic             i_data_l,
    input  logic             i_data_r,
    output logic [WIDTH-1:0] o_data_l,
    output logic [WIDTH-1:0] o_data_r,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_locked,
    output logic             o_frame_err,
    output logic             o_overrun,
    output logic             o_capture_en
);

    localparam logic [5:0] CNT_LAST   = 6'(FRAME_LEN - 1);
    localparam logic [5:0] CNT_CAP_LO = 6'(SKIP);
    localparam logic [5:0] CNT_CAP_HI = 6'(SKIP + WIDTH - 1);
    localparam logic [5:0] CNT_COMMIT = 6'(SKIP + WIDTH);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SYNC,
        ST_LOCKED
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [5:0]       count;
    logic [5:0]       count_nx;
    logic             r_latch_d;
    logic             latch_fall;
    logic             tracking;
    logic             at_last;
    logic             capture;
    logic             commit;
    logic             frame_err_nx;
    logic             load;
    logic             overrun_nx;
    logic [WIDTH-1:0] shift_l;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] word_l;
    logic [WIDTH-1:0] word_r;

    // ------------------------------------------------------------------
    // Frame timing decode
    // ------------------------------------------------------------------
    assign latch_fall = r_latch_d & ~i_latch;
    assign tracking   = (state != ST_HUNT);
    assign at_last    = (count == CNT_LAST);

    // Window test uses registered count/state only, so the probe output
    // does not depend combinationally on the latch pin.
    assign capture = tracking && (count >= CNT_CAP_LO) && (count <= CNT_CAP_HI);

    // A latch edge on the commit cycle restarts the frame and wins.
    assign commit = tracking && !latch_fall && (count == CNT_COMMIT);

    assign o_capture_en = capture;

    // ------------------------------------------------------------------
    // Next-state / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx     = state;
        count_nx     = count;
        frame_err_nx = 1'b0;

        // Count restarts from the edge; otherwise it saturates at the
        // last position, which is where HUNT parks it.
        if (latch_fall) begin
            count_nx = '0;
        end else if (!at_last) begin
            count_nx = count + 6'd1;
        end

        case (state)
            ST_HUNT: begin
                if (latch_fall) begin
                    state_nx = ST_SYNC;
                end
            end
            default: begin
                if (latch_fall) begin
                    if (at_last) begin
                        state_nx = ST_LOCKED;
                    end else begin
                        state_nx     = ST_SYNC;
                        frame_err_nx = 1'b1;
                    end
                end else if (at_last) begin
                    state_nx     = ST_HUNT;
                    frame_err_nx = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_HUNT;
            count       <= '0;
            r_latch_d   <= 1'b0;
            o_locked    <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_nx;
            count       <= count_nx;
            r_latch_d   <= i_latch;
            o_locked    <= (state_nx == ST_LOCKED);
            o_frame_err <= frame_err_nx;
        end
    end

    // ------------------------------------------------------------------
    // Serial capture
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_l <= '0;
            shift_r <= '0;
        end else if (capture) begin
            shift_l <= {shift_l[WIDTH-2:0], i_data_l};
            shift_r <= {shift_r[WIDTH-2:0], i_data_r};
        end
    end

    // ------------------------------------------------------------------
    // Optional mute after frame errors
    // ------------------------------------------------------------------
`ifdef I2S_SEQ_MUTE_ON_ERROR_EN
    logic [1:0] mute_cnt;

    // Every commit consumes one mute slot, whether or not the pair is
    // actually accepted by the output stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mute_cnt <= '0;
        end else if (frame_err_nx) begin
            mute_cnt <= 2'd2;
        end else if (commit && (mute_cnt != '0)) begin
            mute_cnt <= mute_cnt - 2'd1;
        end
    end

    assign word_l = (mute_cnt != '0) ? '0 : shift_l;
    assign word_r = (mute_cnt != '0) ? '0 : shift_r;
`else
    assign word_l = shift_l;
    assign word_r = shift_r;
`endif

    // ------------------------------------------------------------------
    // Output holding stage
    // ------------------------------------------------------------------
    // A commit loads when the holding register is empty or being drained
    // in the same cycle; otherwise the new pair is dropped.
    assign load       = commit && (!o_valid || i_ready);
    assign overrun_nx = commit && o_valid && !i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data_l  <= '0;
            o_data_r  <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= overrun_nx;
            if (load) begin
                o_data_l <= word_l;
                o_data_r <= word_r;
                o_valid  <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
module tb_i2s_frame_sequencer;

    localparam int FL   = 32;
    localparam int SKIP = 13;
    localparam int W    = 16;
    localparam int VW   = 2 * W + 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         latch = 1'b0;
    logic         dl = 1'b0;
    logic         dr = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] o_data_l;
    logic [W-1:0] o_data_r;
    logic         o_valid;
    logic         o_locked;
    logic         o_frame_err;
    logic         o_overrun;
    logic         o_capture_en;
    logic [VW-1:0] dut_vec;

    always #5 clk = ~clk;

    i2s_frame_sequencer #(
        .FRAME_LEN(FL),
        .SKIP     (SKIP),
        .WIDTH    (W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_latch     (latch),
        .i_data_l    (dl),
        .i_data_r    (dr),
        .o_data_l    (o_data_l),
        .o_data_r    (o_data_r),
        .o_valid     (o_valid),
        .i_ready     (ready),
        .o_locked    (o_locked),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_capture_en(o_capture_en)
    );

    assign dut_vec = {o_valid, o_locked, o_frame_err, o_overrun, o_capture_en, o_data_l, o_data_r};

    int checks = 0;
    int errors = 0;

    // Reference model: frame position since the last latch edge, whether a
    // frame is being followed, and the sample words the bench sends.
    bit           m_latch_d, m_aligned, m_locked, m_valid, m_err, m_ovr;
    int           m_count;
    int           m_mute;
    logic [W-1:0] m_dl, m_dr;
    logic [W-1:0] w_l, w_r;
    bit           fix_en;
    logic [W-1:0] fix_l, fix_r;

    // Observations gathered while stepping.
    int            mism, ovr_seen, err_seen, vcyc;
    logic [VW-1:0] mism_act, mism_exp;

    function automatic logic [VW-1:0] exp_vec();
        logic cap;
        cap = m_aligned && (m_count >= SKIP) && (m_count <= SKIP + W - 1);
        return {m_valid, m_locked, m_err, m_ovr, cap, m_dl, m_dr};
    endfunction

    function automatic bit rdy_for(input int mode, input int k);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom);
            default: return (k == SKIP + W);
        endcase
    endfunction

    task automatic new_words();
        if (fix_en) begin
            w_l = fix_l;
            w_r = fix_r;
        end else begin
            w_l = W'($urandom);
            w_r = W'($urandom);
        end
    endtask

    task automatic clear_obs();
        mism = 0; ovr_seen = 0; err_seen = 0; vcyc = 0;
        mism_act = '0; mism_exp = '0;
    endtask

    // One bit clock: drive inputs, advance the model, observe the DUT.
    task automatic cycle(input bit r, input bit lat, input bit rdy);
        bit e, cm, er, zero;
        int pos;
        @(negedge clk);
        rst = r; latch = lat; ready = rdy;
        pos = m_count - SKIP;
        if (pos >= 0 && pos < W) begin
            dl = w_l[W-1-pos];
            dr = w_r[W-1-pos];
        end else begin
            dl = 1'($urandom);
            dr = 1'($urandom);
        end
        if (r) begin
            m_latch_d = 0; m_aligned = 0; m_locked = 0; m_valid = 0;
            m_err = 0; m_ovr = 0; m_count = 0; m_mute = 0;
            m_dl = '0; m_dr = '0;
        end else begin
            e    = m_latch_d && !lat;
            er   = m_aligned && (e ? (m_count != FL - 1) : (m_count == FL - 1));
            cm   = m_aligned && !e && (m_count == SKIP + W);
            zero = 0;
`ifdef I2S_SEQ_MUTE_ON_ERROR_EN
            zero = (m_mute > 0);
            if (cm && m_mute > 0) m_mute--;
            if (er) m_mute = 2;
`endif
            m_ovr = cm && m_valid && !rdy;
            if (cm && (!m_valid || rdy)) begin
                m_valid = 1;
                m_dl = zero ? '0 : w_l;
                m_dr = zero ? '0 : w_r;
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
            if (e) begin
                m_locked  = m_aligned && (m_count == FL - 1);
                m_aligned = 1;
                m_count   = 0;
                new_words();
            end else if (m_count == FL - 1) begin
                m_aligned = 0;
                m_locked  = 0;
            end else begin
                m_count++;
            end
            m_err     = er;
            m_latch_d = lat;
        end
        @(posedge clk);
        #1;
        if (o_overrun)   ovr_seen++;
        if (o_frame_err) err_seen++;
        if (o_valid)     vcyc++;
        if (dut_vec !== exp_vec()) begin
            if (mism == 0) begin
                mism_act = dut_vec;
                mism_exp = exp_vec();
            end
            mism++;
        end
    endtask

    // One frame of len bit clocks; the latch falls on its last cycle.
    task automatic run_frame(input int len, input int mode,
                             output logic [W-1:0] fl, output logic [W-1:0] fr);
        fl = w_l;
        fr = w_r;
        for (int k = 0; k < len; k++)
            cycle(1'b0, (k >= len / 2) && (k <= len - 2), rdy_for(mode, k));
    endtask

    task automatic test_reset();
        clear_obs();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", dut_vec, {VW{1'b0}});
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL model_reset: %0d cycles differ, first got %h want %h", mism, mism_act, mism_exp);
        end
    endtask

    task automatic test_clean_frames();
        logic [W-1:0] a, b;
        fix_en = 1; fix_l = 16'hA5C3; fix_r = 16'h1234;
        new_words();
        clear_obs();
        run_frame(FL, 1, a, b);          // first edge: HUNT -> SYNC
        checks++;
        if (o_locked !== 1'b0) begin
            errors++;
            $display("FAIL locked_after_first_edge: got %b want 0", o_locked);
        end
        run_frame(FL, 1, a, b);          // second edge confirms the frame
        checks++;
        if (o_locked !== 1'b1) begin
            errors++;
            $display("FAIL locked_after_second_edge: got %b want 1", o_locked);
        end
        checks++;
        if ({o_data_l, o_data_r} !== 32'hA5C3_1234) begin
            errors++;
            $display("FAIL clean_data: got %h want %h", {o_data_l, o_data_r}, 32'hA5C3_1234);
        end
        run_frame(FL, 1, a, b);
        run_frame(FL, 1, a, b);
        checks++;
        if (err_seen !== 0 || vcyc !== 3) begin
            errors++;
            $display("FAIL clean_pulses: got err=%0d valid_cycles=%0d want err=0 valid_cycles=3", err_seen, vcyc);
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL model_clean: %0d cycles differ, first got %h want %h", mism, mism_act, mism_exp);
        end
        fix_en = 0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] al, ar, bl, br, cl, cr;
        clear_obs();
        run_frame(FL, 0, al, ar);
        ovr_seen = 0;
        run_frame(FL, 0, bl, br);
        checks++;
        if (ovr_seen !== 1) begin
            errors++;
            $display("FAIL overrun_pulse: got %0d want 1", ovr_seen);
        end
        checks++;
        if ({o_valid, o_data_l, o_data_r} !== {1'b1, al, ar}) begin
            errors++;
            $display("FAIL held_first_pair: got %h want %h", {o_valid, o_data_l, o_data_r}, {1'b1, al, ar});
        end
        ovr_seen = 0;
        run_frame(FL, 3, cl, cr);        // ready only on the commit cycle
        checks++;
        if ({o_valid, o_data_l, o_data_r, 4'(ovr_seen)} !== {1'b1, cl, cr, 4'd0}) begin
            errors++;
            $display("FAIL handshake_on_commit: got %h want %h",
                     {o_valid, o_data_l, o_data_r, 4'(ovr_seen)}, {1'b1, cl, cr, 4'd0});
        end
        run_frame(FL, 1, cl, cr);
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL model_backpressure: %0d cycles differ, first got %h want %h", mism, mism_act, mism_exp);
        end
    endtask

    task automatic test_early_edge();
        logic [W-1:0] a, b;
        clear_obs();
        run_frame(21, 1, a, b);          // edge while count == 20
        checks++;
        if ({4'(err_seen), 4'(vcyc), o_locked} !== {4'd1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL early_edge: got err=%0d valid_cycles=%0d locked=%b want err=1 valid_cycles=0 locked=0",
                     err_seen, vcyc, o_locked);
        end
        err_seen = 0; vcyc = 0;
        run_frame(FL, 1, a, b);
        checks++;
        if ({4'(err_seen), 4'(vcyc), o_locked, o_data_l} !== {4'd0, 4'd1, 1'b1, a}) begin
            errors++;
            $display("FAIL relock_after_early: got err=%0d valid_cycles=%0d locked=%b data=%h want 0 1 1 %h",
                     err_seen, vcyc, o_locked, o_data_l, a);
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL model_early: %0d cycles differ, first got %h want %h", mism, mism_act, mism_exp);
        end
    endtask

    task automatic test_lost_edge();
        logic [W-1:0] a, b;
        int post_err_valid;
        clear_obs();
        post_err_valid = 0;
        for (int k = 0; k < 40; k++) begin
            cycle(1'b0, 1'b1, 1'b1);
            if (err_seen > 0 && o_valid) post_err_valid++;
        end
        checks++;
        if ({4'(err_seen), 4'(post_err_valid), o_locked} !== {4'd1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL lost_edge: got err=%0d post_valid=%0d locked=%b want err=1 post_valid=0 locked=0",
                     err_seen, post_err_valid, o_locked);
        end
        cycle(1'b0, 1'b0, 1'b1);         // edge after the long high
        vcyc = 0;
        run_frame(FL, 1, a, b);
        checks++;
        if ({4'(vcyc), o_locked} !== {4'd1, 1'b1}) begin
            errors++;
            $display("FAIL relock_after_lost: got valid_cycles=%0d locked=%b want 1 1", vcyc, o_locked);
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL model_lost: %0d cycles differ, first got %h want %h", mism, mism_act, mism_exp);
        end
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] a, b;
        clear_obs();
        run_frame(FL, 0, a, b);
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL valid_before_reset: got %b want 1", o_valid);
        end
        for (int k = 0; k < FL; k++) begin
            cycle(k == 22, (k >= FL / 2) && (k <= FL - 2), 1'b0);
            if (k == 22) begin
                checks++;
                if (dut_vec !== '0) begin
                    errors++;
                    $display("FAIL reset_midframe: got %h want %h", dut_vec, {VW{1'b0}});
                end
            end
        end
        vcyc = 0;
        run_frame(FL, 1, a, b);
        checks++;
        if ({4'(vcyc), o_locked} !== {4'd1, 1'b1}) begin
            errors++;
            $display("FAIL recover_after_reset: got valid_cycles=%0d locked=%b want 1 1", vcyc, o_locked);
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL model_reset_midframe: %0d cycles differ, first got %h want %h", mism, mism_act, mism_exp);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        int sel, hold;
        clear_obs();
        for (int f = 0; f < 60; f++) begin
            sel = $urandom_range(9, 0);
            if (sel == 0) begin
                run_frame($urandom_range(31, 4), 2, a, b);
            end else if (sel == 1) begin
                hold = $urandom_range(45, 33);
                for (int k = 0; k < hold; k++) cycle(1'b0, 1'b1, 1'($urandom));
                cycle(1'b0, 1'b0, 1'($urandom));
            end else begin
                run_frame(FL, 2, a, b);
            end
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL model_random: %0d cycles differ, first got %h want %h", mism, mism_act, mism_exp);
        end
    endtask

`ifdef I2S_SEQ_MUTE_ON_ERROR_EN
    task automatic test_mute();
        logic [W-1:0] a, b;
        logic [W-1:0] got [3];
        clear_obs();
        run_frame(FL, 1, a, b);
        fix_en = 1; fix_l = 16'h7FFF; fix_r = 16'h7FFF;
        run_frame(21, 1, a, b);          // early edge, new words fixed
        for (int i = 0; i < 3; i++) begin
            run_frame(FL, 1, a, b);
            got[i] = o_data_l;
        end
        checks++;
        if ({got[0], got[1], got[2]} !== {16'h0000, 16'h0000, 16'h7FFF}) begin
            errors++;
            $display("FAIL mute_sequence: got %h %h %h want 0000 0000 7fff", got[0], got[1], got[2]);
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL model_mute: %0d cycles differ, first got %h want %h", mism, mism_act, mism_exp);
        end
        fix_en = 0;
    endtask
`endif

    initial begin
        fix_en = 0;
        new_words();
        test_reset();
        test_clean_frames();
        test_backpressure();
        test_early_edge();
        test_lost_edge();
        test_reset_midframe();
        test_random();
`ifdef I2S_SEQ_MUTE_ON_ERROR_EN
        test_mute();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
